// File: rtl/color_pkg.sv
// Shared types and helpers for the colour smoothing block.
package color_pkg;

  localparam int COLOR_W = 8;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    WAIT_FIRST,
    RUN,
    LOST
  } state_t;

  // Unsigned distance between two channel values.
  function automatic logic [COLOR_W-1:0] abs_diff(input logic [COLOR_W-1:0] a,
                                                  input logic [COLOR_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/color_acc_chan.sv
// One colour channel: block accumulator, truncating divide, held output and
// the "close to previous average" compare used for stability.
module color_acc_chan
  import color_pkg::*;
#(
  parameter int AVG_LOG2  = 3,
  parameter int STABLE_TH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               sample,
  input  logic               last,
  input  logic [COLOR_W-1:0] din,
  output logic [COLOR_W-1:0] avg_out,
  output logic               near
);

  localparam int ACC_W = COLOR_W + AVG_LOG2;
  localparam logic [COLOR_W-1:0] TH = COLOR_W'(STABLE_TH);

  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sum;
  logic [COLOR_W-1:0] avg;

  // The accumulator is sized so a full block of 255s still fits.
  assign sum  = acc + ACC_W'(din);
  assign avg  = COLOR_W'(sum >> AVG_LOG2);
  assign near = (abs_diff(avg, avg_out) <= TH);

  // Accumulate samples; on the last one register the average and restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      avg_out <= '0;
    end else if (flush) begin
      acc <= '0;
    end else if (sample) begin
      if (last) begin
        acc     <= '0;
        avg_out <= avg;
      end else begin
        acc <= sum;
      end
    end
  end

endmodule

// File: rtl/color_smooth.sv
// Block-averages RGB sensor samples and reports when the colour has settled
// or the sensor has gone quiet.
module color_smooth
  import color_pkg::*;
#(
  parameter int AVG_LOG2   = 3,
  parameter int STABLE_TH  = 8,
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 50_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [COLOR_W-1:0] in_r,
  input  logic [COLOR_W-1:0] in_g,
  input  logic [COLOR_W-1:0] in_b,
  output logic               out_valid,
  output logic [COLOR_W-1:0] out_r,
  output logic [COLOR_W-1:0] out_g,
  output logic [COLOR_W-1:0] out_b,
  output logic               stable,
  output logic               sensor_lost
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int SC_W   = $clog2(STABLE_CNT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [SC_W-1:0]   SC_MAX    = SC_W'(STABLE_CNT);

  state_t              state;
  state_t              next_state;
  logic                enter_lost;
  logic [IDLE_W-1:0]   idle;
  logic [AVG_LOG2-1:0] cnt;
  logic [SC_W-1:0]     stab_cnt;
  logic [SC_W-1:0]     stab_next;
  logic                have_prev;
  logic                flush;
  logic                last;
  logic                done;
  logic [2:0]          near;
  rgb_t                in_px;
  rgb_t                out_px;

  assign in_px = '{r: in_r, g: in_g, b: in_b};
  assign out_r = out_px.r;
  assign out_g = out_px.g;
  assign out_b = out_px.b;

  // clear beats a coincident sample, so a clear on the last sample yields no average.
  assign last  = &cnt;
  assign flush = clear | enter_lost;
  assign done  = in_valid & last & ~clear;

  color_acc_chan #(.AVG_LOG2(AVG_LOG2), .STABLE_TH(STABLE_TH)) u_chan_r (
    .clk(sys_clk), .rst_n(sys_rst_n), .flush(flush), .sample(in_valid), .last(last),
    .din(in_px.r), .avg_out(out_px.r), .near(near[2])
  );

  color_acc_chan #(.AVG_LOG2(AVG_LOG2), .STABLE_TH(STABLE_TH)) u_chan_g (
    .clk(sys_clk), .rst_n(sys_rst_n), .flush(flush), .sample(in_valid), .last(last),
    .din(in_px.g), .avg_out(out_px.g), .near(near[1])
  );

  color_acc_chan #(.AVG_LOG2(AVG_LOG2), .STABLE_TH(STABLE_TH)) u_chan_b (
    .clk(sys_clk), .rst_n(sys_rst_n), .flush(flush), .sample(in_valid), .last(last),
    .din(in_px.b), .avg_out(out_px.b), .near(near[0])
  );

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= WAIT_FIRST;
    else            state <= next_state;
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    next_state = state;
    enter_lost = 1'b0;
    case (state)
      WAIT_FIRST: if (in_valid) next_state = RUN;
      RUN:        if (!in_valid && (idle == IDLE_LAST)) next_state = LOST;
      LOST:       if (in_valid) next_state = RUN;
      default:    next_state = WAIT_FIRST;
    endcase
    if (clear) next_state = WAIT_FIRST;
    enter_lost = (state == RUN) && (next_state == LOST);
  end

  // Idle counter only runs while streaming and restarts on every sample.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                                          idle <= '0;
    else if (flush || (state != RUN) || in_valid)            idle <= '0;
    else                                                     idle <= idle + 1'b1;
  end

  // Sample position within the current block; wraps naturally after the last.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)    cnt <= '0;
    else if (flush)    cnt <= '0;
    else if (in_valid) cnt <= cnt + 1'b1;
  end

  // Consecutive-stable-block count as it would be after the current block.
  always_comb begin
    stab_next = '0;
    if (have_prev && (&near)) stab_next = (stab_cnt == SC_MAX) ? stab_cnt : stab_cnt + 1'b1;
  end

  // Output strobe, stability tracking and lost flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_valid   <= 1'b0;
      sensor_lost <= 1'b0;
      stab_cnt    <= '0;
      have_prev   <= 1'b0;
      stable      <= 1'b0;
    end else begin
      out_valid   <= done;
      sensor_lost <= (next_state == LOST);
      if (flush) begin
        stab_cnt  <= '0;
        have_prev <= 1'b0;
        stable    <= 1'b0;
      end else if (done) begin
        stab_cnt  <= stab_next;
        have_prev <= 1'b1;
        stable    <= (stab_next == SC_MAX) && (next_state != LOST);
      end
    end
  end

endmodule

// File: tb/tb_color_smooth.sv
// Randomised scoreboard bench for color_smooth.
module tb_color_smooth;

  localparam int AVG_LOG2   = 2;
  localparam int STABLE_TH  = 8;
  localparam int STABLE_CNT = 2;
  localparam int TIMEOUT    = 100;
  localparam int NS         = 1 << AVG_LOG2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic       out_valid;
  logic [7:0] out_r, out_g, out_b;
  logic       stable;
  logic       sensor_lost;

  color_smooth #(
    .AVG_LOG2(AVG_LOG2), .STABLE_TH(STABLE_TH), .STABLE_CNT(STABLE_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clear(clear), .in_valid(in_valid),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .out_valid(out_valid),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .stable(stable), .sensor_lost(sensor_lost)
  );

  always #5 sys_clk = ~sys_clk;

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int     r;
    int     g;
    int     b;
    int     st;
    longint at;
  } exp_t;

  exp_t q[$];

  // Reference model: samples of the open block, last emitted average, stable run.
  int  blk_r[$], blk_g[$], blk_b[$];
  int  prev_r = 0, prev_g = 0, prev_b = 0;
  bit  have_prev = 0;
  int  run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int qsum(input int v[$]);
    int s = 0;
    foreach (v[i]) s += v[i];
    return s;
  endfunction

  task automatic model_drop();
    blk_r.delete(); blk_g.delete(); blk_b.delete();
    have_prev = 0;
    run = 0;
  endtask

  task automatic model_sample(input int r, input int g, input int b);
    exp_t e;
    blk_r.push_back(r); blk_g.push_back(g); blk_b.push_back(b);
    if (blk_r.size() == NS) begin
      e.r = qsum(blk_r) / NS;
      e.g = qsum(blk_g) / NS;
      e.b = qsum(blk_b) / NS;
      if (!have_prev) run = 0;
      else if (absd(e.r, prev_r) <= STABLE_TH && absd(e.g, prev_g) <= STABLE_TH &&
               absd(e.b, prev_b) <= STABLE_TH) run = (run < STABLE_CNT) ? run + 1 : run;
      else run = 0;
      have_prev = 1;
      e.st = (run == STABLE_CNT) ? 1 : 0;
      e.at = cyc;
      q.push_back(e);
      prev_r = e.r; prev_g = e.g; prev_b = e.b;
      blk_r.delete(); blk_g.delete(); blk_b.delete();
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send(input int r, input int g, input int b, input int gap);
    in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    model_sample(r, g, b);
    tick(gap);
  endtask

  task automatic send_block(input int r, input int g, input int b);
    for (int i = 0; i < NS; i++) send(r, g, b, int'($urandom_range(0, 2)));
  endtask

  // Monitor: every out_valid must match the oldest expected block.
  always @(negedge sys_clk) begin
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_out_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check("latency_cycle", 32'(cyc), 32'(e.at));
        check("out_r", 32'(out_r), 32'(e.r));
        check("out_g", 32'(out_g), 32'(e.g));
        check("out_b", 32'(out_b), 32'(e.b));
        check("stable", 32'(stable), 32'(e.st));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_r, base_g, base_b;

    // Reset state
    tick(2);
    check("reset_outputs", {25'b0, out_valid, stable, sensor_lost, 4'b0},
          32'b0);
    check("reset_rgb", {8'b0, out_r, out_g, out_b}, 32'b0);
    sys_rst_n = 1'b1;
    tick(2);

    // 1: average and latency
    send(10, 0, 0, 1);
    send(20, 0, 0, 0);
    send(30, 0, 0, 2);
    send(41, 0, 0, 0);
    tick(3);

    // 2: stability build-up, hold, and drop
    for (int k = 0; k < 3; k++) send_block(100, 50, 200);
    tick(1);
    check("stable_after_3", 32'(stable), 32'(1));
    send_block(105, 50, 200);
    send_block(120, 50, 200);
    tick(2);
    check("stable_dropped", 32'(stable), 32'(0));

    // 3: timeout to lost and recovery
    for (int k = 0; k < 3; k++) send_block(90, 90, 90);
    send(40, 40, 40, 0);
    send(40, 40, 40, 0);
    tick(TIMEOUT - 1);
    check("not_lost_yet", 32'(sensor_lost), 32'(0));
    tick(1);
    model_drop();
    check("sensor_lost", 32'(sensor_lost), 32'(1));
    check("stable_when_lost", 32'(stable), 32'(0));
    send(40, 40, 40, 0);
    check("lost_cleared", 32'(sensor_lost), 32'(0));
    for (int i = 1; i < NS; i++) send(40, 40, 40, 1);
    tick(2);

    // 4: clear colliding with the last sample
    for (int i = 0; i < NS - 1; i++) send(int'($urandom_range(0, 255)), 7, 9, 0);
    in_r = 8'd200; in_g = 8'd200; in_b = 8'd200;
    in_valid = 1'b1;
    clear = 1'b1;
    tick(1);
    in_valid = 1'b0;
    clear = 1'b0;
    model_drop();
    tick(3);
    check("held_r_after_clear", 32'(out_r), 32'(prev_r));
    check("held_b_after_clear", 32'(out_b), 32'(prev_b));
    send_block(60, 70, 80);
    tick(2);

    // 5: extremes
    send_block(255, 255, 255);
    send_block(0, 0, 0);
    tick(2);

    // Randomised blocks: a few arbitrary colours, then a jittered steady colour
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NS; i++)
        send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end
    base_r = int'($urandom_range(16, 240));
    base_g = int'($urandom_range(16, 240));
    base_b = int'($urandom_range(16, 240));
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NS; i++)
        send(base_r + int'($urandom_range(0, 3)), base_g + int'($urandom_range(0, 3)),
             base_b + int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    tick(2);
    check("stable_random_steady", 32'(stable), 32'(1));

    // 6: asynchronous reset mid-block
    send(50, 60, 70, 0);
    send(50, 60, 70, 0);
    sys_rst_n = 1'b0;
    #2;
    check("async_rst_flags", {29'b0, out_valid, stable, sensor_lost}, 32'b0);
    check("async_rst_rgb", {8'b0, out_r, out_g, out_b}, 32'b0);
    model_drop();
    prev_r = 0; prev_g = 0; prev_b = 0;
    tick(1);
    sys_rst_n = 1'b1;
    tick(1);
    send_block(8, 8, 8);
    tick(3);

    check("queue_drained", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
